// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like instruction/data arbiter.
// Source IDs are the tag values stored per accepted request, size codes
// follow the SRAM-like bus encoding, DEPTH_DEFAULT is the outstanding limit.
package sram_like_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned DEPTH_DEFAULT = 4;

    // Grant lock: which source (if any) must keep the memory port until
    // its pending address phase is accepted.
    typedef enum logic [1:0] {
        LOCK_FREE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_e;

    function automatic logic size_is_legal(input logic [1:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

endpackage

// File: rtl/sram_like_arbiter_tag.sv
// tag_fifo: DEPTH-deep, 1-bit-wide FIFO of source IDs, one entry per
// accepted address handshake, consumed in order by returning data_ok.
// Ports: clk, resetn (async active-low), push/din, pop, full, empty, head.
// Push while full and pop while empty are ignored.
module tag_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the CPU instruction and data SRAM-like ports
// onto one SRAM-like memory port.
// Ports: clk, resetn (async active-low); inst_* and data_* CPU slave ports
// (req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out); mem_* master
// port (req/wr/size/wstrb/addr/wdata out, addr_ok/data_ok/rdata in).
// Data wins a free arbitration; a stalled address phase locks the grant.
// Returning data_ok is steered by a FIFO of source tags in acceptance order.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    lock_state_e lock_q, lock_d;
    logic        grant;
    logic        granted_req;
    logic        handshake;
    logic        fifo_full, fifo_empty, fifo_head;
    logic        pop;

    always_comb begin
        grant = SRC_INST;
        case (lock_q)
            LOCK_INST: grant = SRC_INST;
            LOCK_DATA: grant = SRC_DATA;
            default:   grant = data_req ? SRC_DATA : SRC_INST;
        endcase
    end

    always_comb begin
        granted_req = inst_req;
        mem_wr      = inst_wr;
        mem_size    = inst_size;
        mem_wstrb   = inst_wstrb;
        mem_addr    = inst_addr;
        mem_wdata   = inst_wdata;
        if (grant == SRC_DATA) begin
            granted_req = data_req;
            mem_wr      = data_wr;
            mem_size    = data_size;
            mem_wstrb   = data_wstrb;
            mem_addr    = data_addr;
            mem_wdata   = data_wdata;
        end
    end

    // resetn gates the combinational request path so nothing escapes
    // while reset is asserted.
    assign mem_req      = granted_req && !fifo_full && resetn;
    assign handshake    = mem_req && mem_addr_ok;
    assign inst_addr_ok = handshake && (grant == SRC_INST);
    assign data_addr_ok = handshake && (grant == SRC_DATA);

    assign pop          = mem_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (fifo_head == SRC_INST);
    assign data_data_ok = pop && (fifo_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Lock only changes on a presented request; a full-FIFO stall drops
    // mem_req and therefore leaves any existing lock in place.
    always_comb begin
        lock_d = lock_q;
        if (handshake) begin
            lock_d = LOCK_FREE;
        end else if (mem_req) begin
            lock_d = (grant == SRC_DATA) ? LOCK_DATA : LOCK_INST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= LOCK_FREE;
        end else begin
            lock_q <= lock_d;
        end
    end

    tag_fifo #(
        .DEPTH(DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (handshake),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = '0;
    logic [3:0]  inst_wstrb = '0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;
    logic rstn_next = 1'b0;
    logic data_wr_mode = 1'b0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: list of outstanding sources in acceptance order plus
    // the source that owns a stalled address phase (-1 when none).
    bit mq[$];
    int mlock = -1;
    int g;
    bit greq, ereq, hs, mpop, mhead;

    always @(negedge resetn) begin
        mq.delete();
        mlock = -1;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            mq.delete();
            mlock = -1;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_inst_addr_ok", inst_addr_ok, 0);
            chk("rst_data_addr_ok", data_addr_ok, 0);
            chk("rst_inst_data_ok", inst_data_ok, 0);
            chk("rst_data_data_ok", data_data_ok, 0);
        end else begin
            g     = (mlock >= 0) ? mlock : (data_req ? 1 : 0);
            greq  = (g == 1) ? data_req : inst_req;
            ereq  = greq && (mq.size() < DEPTH);
            hs    = ereq && mem_addr_ok;
            mpop  = mem_data_ok && (mq.size() > 0);
            mhead = mpop ? mq[0] : 1'b0;
            chk("m_mem_req", mem_req, ereq);
            chk("m_inst_addr_ok", inst_addr_ok, hs && g == 0);
            chk("m_data_addr_ok", data_addr_ok, hs && g == 1);
            chk("m_inst_data_ok", inst_data_ok, mpop && !mhead);
            chk("m_data_data_ok", data_data_ok, mpop && mhead);
            chk("m_inst_rdata", inst_rdata, mem_rdata);
            chk("m_data_rdata", data_rdata, mem_rdata);
            if (ereq) begin
                chk("m_mem_addr", mem_addr, (g == 1) ? data_addr : inst_addr);
                chk("m_mem_wdata", mem_wdata, (g == 1) ? data_wdata : inst_wdata);
                chk("m_mem_wr", mem_wr, (g == 1) ? data_wr : inst_wr);
                chk("m_mem_size", mem_size, (g == 1) ? data_size : inst_size);
                chk("m_mem_wstrb", mem_wstrb, (g == 1) ? data_wstrb : inst_wstrb);
            end
            if (mpop) void'(mq.pop_front());
            if (hs) mq.push_back(g[0]);
            if (hs) mlock = -1;
            else if (ereq) mlock = g;
        end
    end

    // Applies one cycle of inputs after a rising edge and returns just after
    // the following falling edge, where outputs are stable for checking.
    task automatic drive(input bit ir, input bit dr, input bit aok, input bit dok,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] rd);
        @(posedge clk);
        #1;
        resetn      = rstn_next;
        inst_req    = ir;
        inst_wr     = 1'b0;
        inst_size   = SZ_WORD;
        inst_wstrb  = 4'hf;
        inst_addr   = ia;
        inst_wdata  = 32'h1111_0000 ^ ia;
        data_req    = dr;
        data_wr     = data_wr_mode;
        data_size   = SZ_HALF;
        data_wstrb  = 4'h3;
        data_addr   = da;
        data_wdata  = 32'hd0d0_0000 | {16'h0, da[15:0]};
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Held in reset with everything requesting.
        drive(1, 1, 1, 1, 32'h1000, 32'h2000, 32'hdead0001);
        chk("lit_rst_mem_req", mem_req, 0);
        chk("lit_rst_data_addr_ok", data_addr_ok, 0);
        chk("lit_rst_inst_data_ok", inst_data_ok, 0);
        drive(1, 1, 1, 1, 32'h1000, 32'h2000, 32'hdead0002);
        rstn_next = 1'b1;

        // Simultaneous requests: data first, then inst; data_ok in that order.
        drive(1, 1, 1, 0, 32'h1000_0010, 32'h2000_0020, 0);
        chk("lit_both_data_addr_ok", data_addr_ok, 1);
        chk("lit_both_inst_addr_ok", inst_addr_ok, 0);
        chk("lit_both_mem_addr", mem_addr, 32'h2000_0020);
        drive(1, 0, 1, 1, 32'h1000_0010, 32'h2000_0020, 32'haaaa_0001);
        chk("lit_both2_inst_addr_ok", inst_addr_ok, 1);
        chk("lit_both2_data_data_ok", data_data_ok, 1);
        chk("lit_both2_data_rdata", data_rdata, 32'haaaa_0001);
        drive(0, 0, 0, 1, 0, 0, 32'haaaa_0002);
        chk("lit_both3_inst_data_ok", inst_data_ok, 1);
        chk("lit_both3_inst_rdata", inst_rdata, 32'haaaa_0002);
        drive(0, 0, 0, 1, 0, 0, 32'haaaa_0003);
        chk("lit_empty_inst_data_ok", inst_data_ok, 0);
        chk("lit_empty_data_data_ok", data_data_ok, 0);

        // Lock: inst stalls three cycles, data arrives meanwhile.
        drive(1, 0, 0, 0, 32'h1000_0100, 32'h2000_0200, 0);
        chk("lit_lock1_mem_addr", mem_addr, 32'h1000_0100);
        drive(1, 1, 0, 0, 32'h1000_0100, 32'h2000_0200, 0);
        chk("lit_lock2_mem_addr", mem_addr, 32'h1000_0100);
        drive(1, 1, 0, 0, 32'h1000_0100, 32'h2000_0200, 0);
        chk("lit_lock3_mem_addr", mem_addr, 32'h1000_0100);
        drive(1, 1, 1, 0, 32'h1000_0100, 32'h2000_0200, 0);
        chk("lit_lock4_inst_addr_ok", inst_addr_ok, 1);
        chk("lit_lock4_data_addr_ok", data_addr_ok, 0);
        drive(0, 1, 1, 0, 32'h1000_0100, 32'h2000_0200, 0);
        chk("lit_lock5_mem_addr", mem_addr, 32'h2000_0200);
        chk("lit_lock5_data_addr_ok", data_addr_ok, 1);
        drive(0, 0, 0, 1, 0, 0, 32'hbbbb_0001);
        chk("lit_lock6_inst_data_ok", inst_data_ok, 1);
        drive(0, 0, 0, 1, 0, 0, 32'hbbbb_0002);
        chk("lit_lock7_data_data_ok", data_data_ok, 1);

        // Back-to-back: data_ok for N while N+1 is accepted.
        drive(1, 0, 1, 0, 32'h1c00_0000, 32'h0000_0100, 0);
        chk("lit_b2b1_inst_addr_ok", inst_addr_ok, 1);
        drive(0, 1, 1, 1, 32'h1c00_0000, 32'h0000_0100, 32'h0280_0421);
        chk("lit_b2b2_inst_data_ok", inst_data_ok, 1);
        chk("lit_b2b2_inst_rdata", inst_rdata, 32'h0280_0421);
        chk("lit_b2b2_data_addr_ok", data_addr_ok, 1);
        chk("lit_b2b2_mem_addr", mem_addr, 32'h0000_0100);
        drive(0, 0, 0, 1, 0, 0, 32'hcccc_0001);
        chk("lit_b2b3_data_data_ok", data_data_ok, 1);
        chk("lit_b2b3_inst_data_ok", inst_data_ok, 0);

        // Full: four writes outstanding block the fifth, even across a pop.
        data_wr_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 0, 32'h0000_0200 + 32'(i * 4), 0);
            chk("lit_fill_data_addr_ok", data_addr_ok, 1);
        end
        drive(0, 1, 1, 0, 0, 32'h0000_0210, 0);
        chk("lit_full_mem_req", mem_req, 0);
        chk("lit_full_data_addr_ok", data_addr_ok, 0);
        drive(0, 1, 1, 1, 0, 32'h0000_0210, 32'hdddd_0001);
        chk("lit_fullpop_mem_req", mem_req, 0);
        chk("lit_fullpop_data_data_ok", data_data_ok, 1);
        drive(0, 1, 1, 0, 0, 32'h0000_0210, 0);
        chk("lit_reopen_mem_req", mem_req, 1);
        chk("lit_reopen_mem_wr", mem_wr, 1);
        chk("lit_reopen_data_addr_ok", data_addr_ok, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 0, 32'hdddd_0010 + 32'(i));
            chk("lit_drain_data_data_ok", data_data_ok, 1);
        end
        data_wr_mode = 1'b0;

        // Reset with two tags outstanding and a stalled request.
        drive(1, 0, 1, 0, 32'h1000_0400, 32'h2000_0400, 0);
        drive(0, 1, 1, 0, 32'h1000_0400, 32'h2000_0400, 0);
        drive(1, 1, 0, 0, 32'h1000_0404, 32'h2000_0404, 0);
        resetn = 1'b0;
        rstn_next = 1'b0;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        chk("lit_arst_mem_req", mem_req, 0);
        chk("lit_arst_inst_addr_ok", inst_addr_ok, 0);
        chk("lit_arst_data_addr_ok", data_addr_ok, 0);
        chk("lit_arst_inst_data_ok", inst_data_ok, 0);
        chk("lit_arst_data_data_ok", data_data_ok, 0);
        drive(1, 1, 1, 1, 32'h1000_0404, 32'h2000_0404, 32'heeee_0001);
        rstn_next = 1'b1;
        drive(1, 0, 1, 1, 32'h1000_0500, 0, 32'heeee_0002);
        chk("lit_post_inst_addr_ok", inst_addr_ok, 1);
        chk("lit_post_stale_inst_data_ok", inst_data_ok, 0);
        chk("lit_post_stale_data_data_ok", data_data_ok, 0);
        drive(0, 0, 0, 1, 0, 0, 32'heeee_0003);
        chk("lit_post2_inst_data_ok", inst_data_ok, 1);
        chk("lit_post2_inst_rdata", inst_rdata, 32'heeee_0003);
        drive(0, 0, 0, 1, 0, 0, 32'heeee_0004);
        chk("lit_post3_inst_data_ok", inst_data_ok, 0);

        // Pointer wrap: nine alternating single transactions.
        for (int i = 0; i < 9; i++) begin
            drive((i % 2) == 0, (i % 2) == 1, 1, 0,
                  32'h0000_0300 + 32'(i * 4), 32'h0000_0400 + 32'(i * 4), 0);
            chk("lit_wrap_addr_ok", (i % 2) ? data_addr_ok : inst_addr_ok, 1);
            drive(0, 0, 0, 1, 0, 0, 32'h0000_a000 + 32'(i));
            chk("lit_wrap_inst_data_ok", inst_data_ok, (i % 2) == 0);
            chk("lit_wrap_data_data_ok", data_data_ok, (i % 2) == 1);
            chk("lit_wrap_rdata", (i % 2) ? data_rdata : inst_rdata, 32'h0000_a000 + 32'(i));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
